// File: rtl/dram_access_sequencer.sv
// Arbitrates CPU, video and refresh access to one multiplexed-address DRAM bank and sequences RAS/CAS/WE.
// Optional refresh engine guarded by DRAM_ACCESS_SEQUENCER_REFRESH_EN.
module dram_access_sequencer #(
   parameter int ROW_W            = 7,
   parameter int DATA_W           = 8,
   parameter int REFRESH_INTERVAL = 64
) (
   input  logic                clk,
   input  logic                clr_n,
   input  logic                cpu_req,
   input  logic                cpu_we,
   input  logic [2*ROW_W-1:0]  cpu_addr,
   output logic                cpu_ack,
   input  logic                vid_req,
   input  logic [2*ROW_W-1:0]  vid_addr,
   output logic                vid_ack,
   input  logic [DATA_W-1:0]   dram_dq_in,
   output logic [DATA_W-1:0]   rd_data,
   output logic [ROW_W-1:0]    ma,
   output logic                mux_sel,
   output logic                ras_n,
   output logic                cas_n,
   output logic                we_n,
   output logic [1:0]          owner
);

   typedef enum logic [3:0] {
      S_IDLE, S_ROW, S_RAS, S_COL, S_CAS, S_PRE, S_RROW, S_RRAS, S_RHOLD
   } state_t;

   localparam logic [1:0] OWN_NONE = 2'd0;
   localparam logic [1:0] OWN_CPU  = 2'd1;
   localparam logic [1:0] OWN_VID  = 2'd2;
   localparam logic [1:0] OWN_REF  = 2'd3;

   state_t               state, state_nx;
   logic [ROW_W-1:0]     ma_nx;
   logic                 mux_sel_nx, ras_n_nx, cas_n_nx, we_n_nx;
   logic                 cpu_ack_nx, vid_ack_nx;
   logic [1:0]           owner_nx;
   logic [DATA_W-1:0]    rd_data_nx;
   logic [2*ROW_W-1:0]   lat_addr, lat_addr_nx;
   logic                 lat_we, lat_we_nx;
   logic                 refresh_req;

`ifdef DRAM_ACCESS_SEQUENCER_REFRESH_EN
   localparam int TW = $clog2(REFRESH_INTERVAL);

   logic [TW-1:0]    timer;
   logic [ROW_W-1:0] ref_row;
   logic             pending, pending_nx;
   logic             tc, grant_ref, refresh_done;

   assign tc           = (timer == TW'(REFRESH_INTERVAL - 1));
   // Terminal count is treated as a request in its own cycle so an idle bank refreshes without delay.
   assign refresh_req  = pending | tc;
   assign grant_ref    = (state == S_IDLE) && refresh_req;
   assign refresh_done = (state == S_RHOLD);

   always_comb begin
      pending_nx = pending | (tc & ~grant_ref);
      if (refresh_done)
         pending_nx = tc;
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         timer   <= '0;
         ref_row <= '0;
         pending <= 1'b0;
      end else begin
         timer   <= tc ? '0 : timer + 1'b1;
         pending <= pending_nx;
         if (refresh_done)
            ref_row <= ref_row + 1'b1;
      end
   end
`else
   assign refresh_req = 1'b0;
`endif

   always_comb begin
      state_nx    = state;
      ma_nx       = ma;
      mux_sel_nx  = mux_sel;
      ras_n_nx    = ras_n;
      cas_n_nx    = cas_n;
      we_n_nx     = we_n;
      owner_nx    = owner;
      cpu_ack_nx  = 1'b0;
      vid_ack_nx  = 1'b0;
      rd_data_nx  = rd_data;
      lat_addr_nx = lat_addr;
      lat_we_nx   = lat_we;
      case (state)
         S_IDLE: begin
            if (refresh_req) begin
`ifdef DRAM_ACCESS_SEQUENCER_REFRESH_EN
               state_nx   = S_RROW;
               ma_nx      = ref_row;
               mux_sel_nx = 1'b0;
               owner_nx   = OWN_REF;
`endif
            end else if (vid_req) begin
               state_nx    = S_ROW;
               lat_addr_nx = vid_addr;
               lat_we_nx   = 1'b0;
               ma_nx       = vid_addr[ROW_W-1:0];
               mux_sel_nx  = 1'b0;
               owner_nx    = OWN_VID;
            end else if (cpu_req) begin
               state_nx    = S_ROW;
               lat_addr_nx = cpu_addr;
               lat_we_nx   = cpu_we;
               ma_nx       = cpu_addr[ROW_W-1:0];
               mux_sel_nx  = 1'b0;
               owner_nx    = OWN_CPU;
            end
         end
         S_ROW: begin
            state_nx = S_RAS;
            ras_n_nx = 1'b0;
         end
         S_RAS: begin
            state_nx   = S_COL;
            mux_sel_nx = 1'b1;
            ma_nx      = lat_addr[2*ROW_W-1:ROW_W];
            we_n_nx    = ~lat_we;
         end
         S_COL: begin
            state_nx = S_CAS;
            cas_n_nx = 1'b0;
         end
         S_CAS: begin
            state_nx   = S_PRE;
            ras_n_nx   = 1'b1;
            cas_n_nx   = 1'b1;
            we_n_nx    = 1'b1;
            mux_sel_nx = 1'b0;
            cpu_ack_nx = (owner == OWN_CPU);
            vid_ack_nx = (owner == OWN_VID);
            if (!lat_we)
               rd_data_nx = dram_dq_in;
         end
`ifdef DRAM_ACCESS_SEQUENCER_REFRESH_EN
         S_RROW: begin
            state_nx = S_RRAS;
            ras_n_nx = 1'b0;
         end
         S_RRAS: begin
            state_nx = S_RHOLD;
            ras_n_nx = 1'b0;
         end
         S_RHOLD: begin
            state_nx = S_PRE;
            ras_n_nx = 1'b1;
         end
`endif
         S_PRE: begin
            state_nx = S_IDLE;
            owner_nx = OWN_NONE;
         end
         default: begin
            state_nx = S_IDLE;
            ras_n_nx = 1'b1;
            cas_n_nx = 1'b1;
            we_n_nx  = 1'b1;
            owner_nx = OWN_NONE;
         end
      endcase
   end

   // Every output is the registered image of its next-state value, so the strobes are glitch-free.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state    <= S_IDLE;
         ma       <= '0;
         mux_sel  <= 1'b0;
         ras_n    <= 1'b1;
         cas_n    <= 1'b1;
         we_n     <= 1'b1;
         owner    <= OWN_NONE;
         cpu_ack  <= 1'b0;
         vid_ack  <= 1'b0;
         rd_data  <= '0;
         lat_addr <= '0;
         lat_we   <= 1'b0;
      end else begin
         state    <= state_nx;
         ma       <= ma_nx;
         mux_sel  <= mux_sel_nx;
         ras_n    <= ras_n_nx;
         cas_n    <= cas_n_nx;
         we_n     <= we_n_nx;
         owner    <= owner_nx;
         cpu_ack  <= cpu_ack_nx;
         vid_ack  <= vid_ack_nx;
         rd_data  <= rd_data_nx;
         lat_addr <= lat_addr_nx;
         lat_we   <= lat_we_nx;
      end
   end

endmodule

// File: tb/tb_dram_access_sequencer.sv
// Directed bench for dram_access_sequencer: grant/ack scoreboard queues checked by a negedge monitor,
// plus cycle-exact strobe checks in the driver. Refresh scenarios need DRAM_ACCESS_SEQUENCER_REFRESH_EN.
module tb_dram_access_sequencer;

   localparam int RW = 7;
   localparam int DW = 8;

   logic            clk = 1'b0;
   logic            clr_n = 1'b1;
   logic            cpu_req = 1'b0;
   logic            cpu_we = 1'b0;
   logic [2*RW-1:0] cpu_addr = '0;
   logic            cpu_ack;
   logic            vid_req = 1'b0;
   logic [2*RW-1:0] vid_addr = '0;
   logic            vid_ack;
   logic [DW-1:0]   dram_dq_in = '0;
   logic [DW-1:0]   rd_data;
   logic [RW-1:0]   ma;
   logic            mux_sel, ras_n, cas_n, we_n;
   logic [1:0]      owner;

   dram_access_sequencer #(.ROW_W(RW), .DATA_W(DW), .REFRESH_INTERVAL(64)) dut (
      .clk(clk), .clr_n(clr_n),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_ack(cpu_ack),
      .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack),
      .dram_dq_in(dram_dq_in), .rd_data(rd_data), .ma(ma), .mux_sel(mux_sel),
      .ras_n(ras_n), .cas_n(cas_n), .we_n(we_n), .owner(owner)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int cyc;
   logic [15:0] grant_q[$];   // {7'b0, owner, row}
   logic [15:0] ack_q[$];     // {6'b0, source, rd_data}
   logic [DW-1:0] last_rd = '0;

   always @(posedge clk or negedge clr_n)
      if (!clr_n) cyc <= 0;
      else        cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every grant and every ack pulse must match the head of its queue.
   logic [1:0] prev_owner = 2'd0;
   always @(negedge clk) begin
      logic [15:0] e;
      logic [1:0]  src;
      if (!clr_n) begin
         prev_owner = 2'd0;
      end else begin
         if (owner != 2'd0 && prev_owner == 2'd0) begin
            if (grant_q.size() == 0) chk("unexpected_grant", owner, 0);
            else begin
               e = grant_q.pop_front();
               chk("grant_owner", owner, e[8:7]);
               chk("grant_row", ma, e[6:0]);
            end
         end
         if (cpu_ack || vid_ack) begin
            src = {vid_ack, cpu_ack};
            if (ack_q.size() == 0) chk("unexpected_ack", src, 0);
            else begin
               e = ack_q.pop_front();
               chk("ack_source", src, e[9:8]);
               chk("ack_rd_data", rd_data, e[7:0]);
            end
         end
         prev_owner = owner;
      end
   end

   task automatic wait_owner(input logic [1:0] o, input int limit, output int t);
      bit seen = 0;
      for (int i = 0; i < limit && !seen; i++) begin
         @(negedge clk);
         if (owner == o) seen = 1;
      end
      if (!seen) begin
         failures++;
         $display("FAIL wait_owner: owner 0x%0h never appeared within %0d cycles", o, limit);
      end
      t = cyc;
   endtask

   task automatic wait_ack(input bit vid, input int limit, output int t);
      bit seen = 0;
      for (int i = 0; i < limit && !seen; i++) begin
         @(negedge clk);
         if (vid ? vid_ack : cpu_ack) seen = 1;
      end
      if (!seen) begin
         failures++;
         $display("FAIL wait_ack: ack (vid=%0d) never appeared within %0d cycles", vid, limit);
      end
      t = cyc;
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2 clr_n = 1'b0;
      repeat (2) @(negedge clk);
      clr_n = 1'b1;
      last_rd = '0;
   endtask

   // Drives one access and checks the strobes edge by edge from the grant (E0) to IDLE (E5).
   task automatic run_access(input logic [1:0] src, input logic [2*RW-1:0] addr,
                             input logic we, input logic [DW-1:0] dq);
      int t;
      logic [RW-1:0] row, col;
      row = addr[RW-1:0];
      col = addr[2*RW-1:RW];
      dram_dq_in = dq;
      if (src == 2'd1) begin cpu_addr = addr; cpu_we = we; cpu_req = 1'b1; end
      else begin vid_addr = addr; vid_req = 1'b1; end
      grant_q.push_back({7'd0, src, row});
      ack_q.push_back({6'd0, src, (we ? last_rd : dq)});
      if (!we) last_rd = dq;
      wait_owner(src, 200, t);
      chk("e0_mux_sel", mux_sel, 0);
      chk("e0_ras_n", ras_n, 1);
      @(negedge clk);
      chk("e1_ras_n", ras_n, 0);
      chk("e1_ma_row", ma, row);
      chk("e1_cas_n", cas_n, 1);
      @(negedge clk);
      chk("e2_mux_sel", mux_sel, 1);
      chk("e2_ma_col", ma, col);
      chk("e2_we_n", we_n, !we);
      chk("e2_cas_n", cas_n, 1);
      @(negedge clk);
      chk("e3_cas_n", cas_n, 0);
      chk("e3_ras_n", ras_n, 0);
      chk("e3_we_n", we_n, !we);
      @(negedge clk);
      chk("e4_ack", (src == 2'd1) ? cpu_ack : vid_ack, 1);
      chk("e4_strobes", {ras_n, cas_n, we_n, mux_sel}, 4'b1110);
      cpu_req = 1'b0;
      vid_req = 1'b0;
      @(negedge clk);
      chk("e5_ack_low", {cpu_ack, vid_ack}, 0);
      chk("e5_owner", owner, 0);
   endtask

   initial begin
      int tv, tc_, ta, tb_;
      #2 clr_n = 1'b0;
      #1;
      chk("rst_strobes", {ras_n, cas_n, we_n, mux_sel}, 4'b1110);
      chk("rst_ma", ma, 0);
      chk("rst_owner", owner, 0);
      chk("rst_acks", {cpu_ack, vid_ack}, 0);
      chk("rst_rd_data", rd_data, 0);
      @(negedge clk);
      clr_n = 1'b1;

      // Read of 0x0A85: row 0x05, column 0x15.
      run_access(2'd1, 14'h0A85, 1'b0, 8'h5A);
      chk("read_rd_data", rd_data, 8'h5A);
      // Write keeps rd_data.
      run_access(2'd1, 14'h1F22, 1'b1, 8'hA7);
      chk("write_rd_data_kept", rd_data, 8'h5A);
      run_access(2'd2, 14'h3C7F, 1'b0, 8'h3C);

      // Simultaneous requests: video first, CPU six clocks later.
      dram_dq_in = 8'hC3;
      vid_addr = 14'h0411; cpu_addr = 14'h2A2B; cpu_we = 1'b0;
      vid_req = 1'b1; cpu_req = 1'b1;
      grant_q.push_back({7'd0, 2'd2, 7'h11});
      grant_q.push_back({7'd0, 2'd1, 7'h2B});
      ack_q.push_back({6'd0, 2'd2, 8'hC3});
      ack_q.push_back({6'd0, 2'd1, 8'hC3});
      last_rd = 8'hC3;
      wait_owner(2'd2, 50, tv);
      wait_ack(1'b1, 20, ta);
      vid_req = 1'b0;
      wait_owner(2'd1, 50, tc_);
      chk("cpu_grant_after_vid", tc_ - tv, 6);
      wait_ack(1'b0, 20, tb_);
      cpu_req = 1'b0;
      chk("cpu_ack_after_vid_ack", tb_ - ta, 6);

`ifdef DRAM_ACCESS_SEQUENCER_REFRESH_EN
      // Idle refresh: grant at clock 64 from reset, RAS-only, two clocks of ras_n low.
      do_reset();
      grant_q.push_back({7'd0, 2'd3, 7'd0});
      grant_q.push_back({7'd0, 2'd3, 7'd1});
      wait_owner(2'd3, 100, tv);
      chk("ref1_grant_cycle", tv, 64);
      chk("ref1_ras_n_e0", ras_n, 1);
      @(negedge clk);
      chk("ref1_ras_n_e1", ras_n, 0);
      chk("ref1_cas_we_e1", {cas_n, we_n}, 2'b11);
      @(negedge clk);
      chk("ref1_ras_n_e2", ras_n, 0);
      chk("ref1_cas_we_e2", {cas_n, we_n}, 2'b11);
      @(negedge clk);
      chk("ref1_ras_n_pre", ras_n, 1);
      chk("ref1_no_ack", {cpu_ack, vid_ack}, 0);
      @(negedge clk);
      chk("ref1_owner_idle", owner, 0);
      wait_owner(2'd3, 100, tv);
      chk("ref2_grant_cycle", tv, 128);

      // Refresh falls due during a video access; it beats the waiting CPU at the next IDLE.
      while (cyc < 189) @(negedge clk);
      dram_dq_in = 8'h96;
      vid_addr = 14'h1A33; vid_req = 1'b1;
      grant_q.push_back({7'd0, 2'd2, 7'h33});
      grant_q.push_back({7'd0, 2'd3, 7'd2});
      grant_q.push_back({7'd0, 2'd1, 7'h44});
      ack_q.push_back({6'd0, 2'd2, 8'h96});
      ack_q.push_back({6'd0, 2'd1, 8'h96});
      last_rd = 8'h96;
      @(negedge clk);
      chk("vid_grant_cycle", cyc, 190);
      chk("vid_owner", owner, 2);
      cpu_addr = 14'h0944; cpu_we = 1'b1; cpu_req = 1'b1;
      wait_ack(1'b1, 20, ta);
      vid_req = 1'b0;
      wait_owner(2'd3, 20, tv);
      chk("ref3_grant_cycle", tv, 196);
      wait_owner(2'd1, 20, tc_);
      chk("cpu_after_ref_cycle", tc_, 201);
      wait_ack(1'b0, 20, tb_);
      cpu_req = 1'b0;
      chk("cpu_write_rd_kept", rd_data, 8'h96);
`endif

      // Reset while in CAS: strobes release at once, no ack.
      do_reset();
      dram_dq_in = 8'hE1;
      cpu_addr = 14'h0D0D; cpu_we = 1'b0; cpu_req = 1'b1;
      grant_q.push_back({7'd0, 2'd1, 7'h0D});
      wait_owner(2'd1, 50, tv);
      repeat (3) @(negedge clk);
      chk("pre_abort_cas_n", cas_n, 0);
      #2 clr_n = 1'b0;
      #1;
      chk("abort_strobes", {ras_n, cas_n, we_n, mux_sel}, 4'b1110);
      chk("abort_owner", owner, 0);
      chk("abort_acks", {cpu_ack, vid_ack}, 0);
      cpu_req = 1'b0;
      repeat (2) @(negedge clk);
      clr_n = 1'b1;
      last_rd = '0;
      run_access(2'd1, 14'h3355, 1'b0, 8'h71);
      chk("post_abort_rd_data", rd_data, 8'h71);
`ifdef DRAM_ACCESS_SEQUENCER_REFRESH_EN
      grant_q.push_back({7'd0, 2'd3, 7'd0});
      wait_owner(2'd3, 100, tv);
      chk("post_abort_ref_cycle", tv, 64);
      repeat (5) @(negedge clk);
`endif

      repeat (3) @(negedge clk);
      chk("grant_q_drained", grant_q.size(), 0);
      chk("ack_q_drained", ack_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog");
   end

endmodule
